cordic_sequencer: RTL and testbench



---
 rtl/cordic_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cordic_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC engine: one micro-rotation per cycle, circular or hyperbolic,
// rotation or vectoring, with its own angle tables, iteration control and start/done handshake.
module cordic_sequencer #(
  parameter int unsigned p_WIDTH      = 32,
  parameter int unsigned p_ITER       = 20,
  parameter int unsigned p_HYP_REPEAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_vector,
  input  logic [4:0]         i_niter,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  output logic               o_busy,
  output logic               o_done,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Angles at 32 bits, 2^32 = one full turn; entries floor-rounded. Covers shifts 0..30.
  function automatic logic [31:0] angle_lut(input logic circ, input logic [4:0] idx);
    logic [31:0] a;
    a = 32'h0;
    if (circ) begin
      case (idx)
        5'd0:  a = 32'h20000000;  5'd1:  a = 32'h12E4051D;  5'd2:  a = 32'h09FB385B;
        5'd3:  a = 32'h051111D4;  5'd4:  a = 32'h028B0D43;  5'd5:  a = 32'h0145D7E1;
        5'd6:  a = 32'h00A2F61E;  5'd7:  a = 32'h00517C55;  5'd8:  a = 32'h0028BE53;
        5'd9:  a = 32'h00145F2E;  5'd10: a = 32'h000A2F98;  5'd11: a = 32'h000517CC;
        5'd12: a = 32'h00028BE6;  5'd13: a = 32'h000145F3;  5'd14: a = 32'h0000A2F9;
        5'd15: a = 32'h0000517C;  5'd16: a = 32'h000028BE;  5'd17: a = 32'h0000145F;
        5'd18: a = 32'h00000A2F;  5'd19: a = 32'h00000517;  5'd20: a = 32'h0000028B;
        5'd21: a = 32'h00000145;  5'd22: a = 32'h000000A2;  5'd23: a = 32'h00000051;
        5'd24: a = 32'h00000028;  5'd25: a = 32'h00000014;  5'd26: a = 32'h0000000A;
        5'd27: a = 32'h00000005;  5'd28: a = 32'h00000002;  5'd29: a = 32'h00000001;
        default: a = 32'h0;
      endcase
    end else begin
      case (idx)
        5'd1:  a = 32'h1661788D;  5'd2:  a = 32'h0A680D61;  5'd3:  a = 32'h051EA6FC;
        5'd4:  a = 32'h028CBFDD;  5'd5:  a = 32'h01460E34;  5'd6:  a = 32'h00A2FCE8;
        5'd7:  a = 32'h00517D2E;  5'd8:  a = 32'h0028BE6E;  5'd9:  a = 32'h00145F32;
        5'd10: a = 32'h000A2F98;  5'd11: a = 32'h000517CC;  5'd12: a = 32'h00028BE6;
        5'd13: a = 32'h000145F3;  5'd14: a = 32'h0000A2F9;  5'd15: a = 32'h0000517C;
        5'd16: a = 32'h000028BE;  5'd17: a = 32'h0000145F;  5'd18: a = 32'h00000A2F;
        5'd19: a = 32'h00000517;  5'd20: a = 32'h0000028B;  5'd21: a = 32'h00000145;
        5'd22: a = 32'h000000A2;  5'd23: a = 32'h00000051;  5'd24: a = 32'h00000028;
        5'd25: a = 32'h00000014;  5'd26: a = 32'h0000000A;  5'd27: a = 32'h00000005;
        5'd28: a = 32'h00000002;  5'd29: a = 32'h00000001;
        default: a = 32'h0;
      endcase
    end
    return a;
  endfunction

  state_e state_q, state_d;
  logic signed [p_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [p_WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d, res_z_q, res_z_d;
  logic mode_q, mode_d, vector_q, vector_d, rep_q, rep_d;
  logic [4:0] shift_q, shift_d, count_q, count_d, n_q, n_d;

  logic [4:0] niter_eff;
  logic signed [31:0] lut32;
  logic signed [p_WIDTH-1:0] lut, x_sh, y_sh, x_n, y_n, z_n;
  logic dir, hold_shift;

  assign niter_eff = (i_niter == 5'd0 || 32'(i_niter) > p_ITER) ? 5'(p_ITER) : i_niter;

  // Single micro-rotation on the current registers; dir = 1 rotates counter-clockwise.
  always_comb begin
    lut32 = $signed(angle_lut(mode_q, shift_q)) >>> (32 - p_WIDTH);
    lut   = lut32[p_WIDTH-1:0];
    x_sh  = x_q >>> shift_q;
    y_sh  = y_q >>> shift_q;
    dir   = vector_q ? y_q[p_WIDTH-1] : ~z_q[p_WIDTH-1];
    if (dir) begin
      x_n = mode_q ? x_q - y_sh : x_q + y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - lut;
    end else begin
      x_n = mode_q ? x_q + y_sh : x_q - y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + lut;
    end
  end

  // Hyperbolic convergence needs shifts 4 and 13 executed twice.
  assign hold_shift = !mode_q && (p_HYP_REPEAT != 0) && !rep_q &&
                      (shift_q == 5'd4 || shift_q == 5'd13);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    res_z_d  = res_z_q;
    mode_d   = mode_q;
    vector_d = vector_q;
    rep_d    = rep_q;
    shift_d  = shift_q;
    count_d  = count_q;
    n_d      = n_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          x_d      = $signed(i_x);
          y_d      = $signed(i_y);
          z_d      = $signed(i_z);
          mode_d   = i_mode;
          vector_d = i_vector;
          n_d      = niter_eff;
          shift_d  = i_mode ? 5'd0 : 5'd1;
          count_d  = 5'd0;
          rep_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        x_d     = x_n;
        y_d     = y_n;
        z_d     = z_n;
        count_d = count_q + 5'd1;
        if (hold_shift) begin
          rep_d = 1'b1;
        end else begin
          shift_d = shift_q + 5'd1;
          rep_d   = 1'b0;
        end
        if (count_d == n_q) begin
          res_x_d = x_n;
          res_y_d = y_n;
          res_z_d = z_n;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      res_x_q  <= '0;
      res_y_q  <= '0;
      res_z_q  <= '0;
      mode_q   <= 1'b0;
      vector_q <= 1'b0;
      rep_q    <= 1'b0;
      shift_q  <= '0;
      count_q  <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
      res_z_q  <= res_z_d;
      mode_q   <= mode_d;
      vector_q <= vector_d;
      rep_q    <= rep_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      n_q      <= n_d;
    end
  end

  assign o_busy = (state_q != StIdle);
  assign o_done = (state_q == StDone);
  assign o_x    = res_x_q;
  assign o_y    = res_y_q;
  assign o_z    = res_z_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer: table of jobs with hand-computed results plus
// handshake, held-start and mid-run reset sequences.
module tb_cordic_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n, start, mode, vector, busy, done;
  logic [4:0] niter;
  logic [W-1:0] x, y, z, ox, oy, oz;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_sequencer #(.p_WIDTH(W), .p_ITER(20), .p_HYP_REPEAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_vector(vector),
    .i_niter(niter), .i_x(x), .i_y(y), .i_z(z),
    .o_busy(busy), .o_done(done), .o_x(ox), .o_y(oy), .o_z(oz)
  );

  typedef struct {
    logic mode;
    logic vector;
    logic [4:0] niter;
    longint x, y, z;
    longint ex, ey, ez;
    longint tol_xy, tol_z;
    int lat;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input longint got, input longint exp,
                       input longint tol);
    longint d;
    n_cmp++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  task automatic drive(input vec_t v);
    mode   = v.mode;
    vector = v.vector;
    niter  = v.niter;
    x      = v.x[W-1:0];
    y      = v.y[W-1:0];
    z      = v.z[W-1:0];
  endtask

  // Runs one job; lat counts the start-sampling edge as cycle 1. noise pulses start in RUN and DONE.
  task automatic run_job(input vec_t v, input bit noise, output int lat, output int bw,
                         output int dw, output longint rx, output longint ry, output longint rz);
    lat = 0; bw = 0; dw = 0; rx = 0; ry = 0; rz = 0;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    x      = ~x;
    y      = x ^ 32'h5A5A_A5A5;
    z      = ~z;
    mode   = ~mode;
    vector = ~vector;
    niter  = 5'd3;
    for (int c = 1; c <= 64; c++) begin
      if (noise) start = 1'b0;
      if (busy) bw++;
      if (done) begin
        dw++;
        if (noise) start = 1'b1;
        if (lat == 0) begin
          lat = c;
          rx = longint'($signed(ox));
          ry = longint'($signed(oy));
          rz = longint'($signed(oz));
        end
      end
      if (noise && c == 3) start = 1'b1;
      if (!busy && c > 1) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bw, dw, nd, gap;
    longint rx, ry, rz;

    //            mode vec niter x            y           z           ex           ey          ez          tol    tolz   lat
    vt[0] = '{1'b1, 1'b0, 5'd20, 1304065673, 0,          119304647,  2114858546,  372906622,  0,          16384, 11930, 21};
    vt[1] = '{1'b1, 1'b1, 5'd20, 644245094,  644245094,  0,          1500363502,  0,          536870912,  16384, 11930, 21};
    vt[2] = '{1'b0, 1'b0, 5'd20, 324135008,  0,          119304647,  272534358,   47089074,   0,          4096,  11930, 21};
    vt[3] = '{1'b1, 1'b0, 5'd5,  1048576,    0,          0,          1725440,     25600,      -10141175,  0,     0,     6};
    vt[4] = '{1'b0, 1'b0, 5'd5,  1048576,    0,          0,          869760,      37440,      -29443190,  0,     0,     6};
    vt[5] = vt[0]; vt[5].niter = 5'd0;
    vt[6] = vt[0]; vt[6].niter = 5'd31;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; vector = 1'b0; niter = '0;
    x = '0; y = '0; z = '0;
    #12;
    check("reset busy", busy, 0, 0);
    check("reset done", done, 0, 0);
    check("reset x", ox, 0, 0);
    check("reset y", oy, 0, 0);
    check("reset z", oz, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_job(vt[i], 1'b0, lat, bw, dw, rx, ry, rz);
      check($sformatf("vec%0d latency", i), lat, vt[i].lat, 0);
      check($sformatf("vec%0d busy width", i), bw, vt[i].lat, 0);
      check($sformatf("vec%0d done width", i), dw, 1, 0);
      check($sformatf("vec%0d x", i), rx, vt[i].ex, vt[i].tol_xy);
      check($sformatf("vec%0d y", i), ry, vt[i].ey, vt[i].tol_xy);
      check($sformatf("vec%0d z", i), rz, vt[i].ez, vt[i].tol_z);
    end

    // Start pulses during RUN and DONE must be ignored; results then hold while idle.
    run_job(vt[4], 1'b1, lat, bw, dw, rx, ry, rz);
    check("noise latency", lat, 6, 0);
    check("noise done width", dw, 1, 0);
    check("noise x", rx, vt[4].ex, 0);
    check("noise z", rz, vt[4].ez, 0);
    bw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (busy || done) bw++;
    end
    check("no queued job", bw, 0, 0);
    check("hold x", longint'($signed(ox)), vt[4].ex, 0);
    check("hold y", longint'($signed(oy)), vt[4].ey, 0);

    // Start held high: back-to-back jobs with a single idle cycle between them.
    @(negedge clk);
    drive(vt[3]);
    start = 1'b1;
    nd = 0; gap = 0; rx = 0; ry = 0; rz = 0;
    for (int c = 0; c < 60 && nd < 2; c++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        rx = longint'($signed(ox));
        ry = longint'($signed(oy));
        rz = longint'($signed(oz));
      end else if (nd == 1 && !busy) begin
        gap++;
      end
    end
    start = 1'b0;
    check("held start dones", nd, 2, 0);
    check("held start idle gap", gap, 1, 0);
    check("held start x", rx, vt[3].ex, 0);
    check("held start y", ry, vt[3].ey, 0);
    check("held start z", rz, vt[3].ez, 0);
    repeat (3) @(posedge clk);

    // Reset at RUN cycle 7 aborts the job and clears outputs immediately.
    @(negedge clk);
    drive(vt[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0, 0);
    check("async reset done", done, 0, 0);
    check("async reset x", ox, 0, 0);
    check("async reset y", oy, 0, 0);
    check("async reset z", oz, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check("no done after abort", nd, 0, 0);
    run_job(vt[0], 1'b0, lat, bw, dw, rx, ry, rz);
    check("post-reset latency", lat, 21, 0);
    check("post-reset x", rx, vt[0].ex, vt[0].tol_xy);
    check("post-reset y", ry, vt[0].ey, vt[0].tol_xy);
    check("post-reset z", rz, vt[0].ez, vt[0].tol_z);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
